cordic_fixedpoint_quadrant_restore: RTL and testbench
=====================================================

# cordic_fixedpoint_quadrant_restore

Back-end of the CORDIC angle-normalization path. For each phase sample, the front-end comparator emits a one-hot octant code, and the CORDIC core then computes cos/sin of the reduced angle. This block queues the octant codes in order and pairs each one with the matching CORDIC result. It then applies the swap/negate correction that maps the result back to the full [-180°, 180°) range and presents it on a valid/ready output.

## Interface
Parameters:
- W, 24: data width of cos/sin, two's complement.
- DEPTH, 16: octant-tag FIFO depth, power of 2, ≥ 2.

Ports:
- iClk  in  1  clock; all logic rising-edge.
- iRst_n  in  1  synchronous, active-low reset.
- iTag_valid  in  1  octant code present.
- iTag  in  8  one-hot octant code. Bit k = range k: 0 [0,45], 1 [-45,0), 2 [-90,-45), 3 [-135,-90), 4 [-180,-135), 5 [135,180), 6 [90,135), 7 (45,90].
- oTag_ready  out  1  FIFO not full.
- oTag_count  out  $clog2(DEPTH)+1  FIFO occupancy.
- iData_valid  in  1  CORDIC result valid.
- iCos, iSin  in  W  cos/sin of reduced angle.
- oData_ready  out  1  block can accept a result.
- oValid  out  1  corrected result valid.
- oCos, oSin  out  W  corrected cos/sin of original phase.
- oErr  out  1  qualifies current oValid beat: invalid tag (zero or multi-hot).
- oOrphan  out  1  sticky: a result arrived with the FIFO empty.
- iReady  in  1  downstream accepts.

## Operation
- Tag push: when iTag_valid && oTag_ready, write iTag at wr_ptr; wr_ptr++ mod DEPTH.
- oTag_ready = (count != DEPTH), combinational from registered count.
- Data accept: when iData_valid && oData_ready.
  - oData_ready = !oValid || iReady. It does not depend on FIFO state, so no deadlock.
  - If the FIFO is non-empty, pop the tag at rd_ptr and load the output register with the corrected value.
  - If the FIFO is empty, drop the sample, set oOrphan, and leave the output unchanged.
- Correction (c = iCos, s = iSin, neg() saturating):
  - bits 0,1: (c, s)
  - bits 2,3: (s, neg(c))
  - bits 4,5: (neg(c), neg(s))
  - bits 6,7: (neg(s), c)
- neg(x): if x == 2^(W-1) (most negative), result = 2^(W-1)-1; otherwise -x.
- Invalid tag (zero or more than one bit set): the tag is still popped, oCos = oSin = 0, oErr = 1 for that beat.
- Output register holds while oValid && !iReady. oValid clears on iReady when no new accept occurs.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push while full: ignored, since oTag_ready = 0. Pop while empty: orphan rule above.
- No bypass: a tag pushed in cycle N is poppable from cycle N+1. CORDIC latency ≥ 1 guarantees this.
- oOrphan clears only on reset.

## Timing
- Reset (iRst_n = 0 at a rising edge) forces:
  - pointers = 0, count = 0
  - oValid = 0, oCos = oSin = 0, oErr = 0, oOrphan = 0
- After reset: oTag_ready = 1, oData_ready = 1, oTag_count = 0.
- A reset asserted mid-stream discards all queued tags and any pending output. A held output beat is lost.
- Latency: data accepted at edge N produces oValid/oCos/oSin/oErr visible after edge N (registered, 1 cycle).
- Throughput: 1 result per cycle while iReady = 1.
- oTag_count updates one cycle after a push/pop edge and equals pushes minus pops.
- Ordering: results pair with tags strictly in FIFO order.

## Test plan
- Reset, push tag 0x04, next cycle data c = 0x200000, s = 0x100000, iReady = 1 -> one cycle later oValid = 1, oCos = 0x100000, oSin = 0xE00000, oErr = 0.
- Push tags 0x01, 0x10, 0x40, 0x80, then 4 data beats of c = 0x300000, s = 0x080000 -> outputs in order:
  - (0x300000, 0x080000)
  - (0xD00000, 0xF80000)
  - (0xF80000, 0x300000)
  - (0xF80000, 0x300000)
- Saturation: tag 0x20, c = 0x800000, s = 0x800000 -> oCos = oSin = 0x7FFFFF.
- FIFO full: push 16 tags with no data -> oTag_ready = 0, oTag_count = 16, 17th push ignored. Pop one -> oTag_ready = 1.
- Backpressure: iReady = 0 with a valid output -> output held stable and oData_ready = 0. Raise iReady -> next beat accepted the same cycle.
- Error paths:
  - tag 0x03 -> oErr = 1, outputs 0.
  - data with empty FIFO -> no oValid, oOrphan = 1 until reset.

Source files
------------

// File: rtl/cordic_fixedpoint_quadrant_restore.sv
// CORDIC back-end: pairs queued octant tags with CORDIC results and
// restores the full-range cos/sin with a swap/negate correction.
module cordic_fixedpoint_quadrant_restore #(
  parameter int W     = 24,
  parameter int DEPTH = 16
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iTag_valid,
  input  logic [7:0]                 iTag,
  output logic                       oTag_ready,
  output logic [$clog2(DEPTH):0]     oTag_count,
  input  logic                       iData_valid,
  input  logic [W-1:0]               iCos,
  input  logic [W-1:0]               iSin,
  output logic                       oData_ready,
  output logic                       oValid,
  output logic [W-1:0]               oCos,
  output logic [W-1:0]               oSin,
  output logic                       oErr,
  output logic                       oOrphan,
  input  logic                       iReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [W-1:0] MinV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MaxV = ~MinV;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] count;

  logic          push;
  logic          accept;
  logic          empty;
  logic          pop;
  logic [7:0]    tagHead;
  logic          oneHot;
  logic [W-1:0]  corrCos;
  logic [W-1:0]  corrSin;

  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return (x == MinV) ? MaxV : -x;
  endfunction

  assign oTag_ready  = (count != Full);
  assign oTag_count  = count;
  assign oData_ready = !oValid || iReady;
  assign push   = iTag_valid && oTag_ready;
  assign accept = iData_valid && oData_ready;
  assign empty  = (count == '0);
  assign pop    = accept && !empty;

  assign tagHead = mem[rdPtr];
  assign oneHot  = (tagHead != 8'd0) &&
                   ((tagHead & (tagHead - 8'd1)) == 8'd0);

  always_comb begin
    corrCos = '0;
    corrSin = '0;
    if (oneHot) begin
      unique case (1'b1)
        tagHead[0], tagHead[1]: begin
          corrCos = iCos;
          corrSin = iSin;
        end
        tagHead[2], tagHead[3]: begin
          corrCos = iSin;
          corrSin = neg(iCos);
        end
        tagHead[4], tagHead[5]: begin
          corrCos = neg(iCos);
          corrSin = neg(iSin);
        end
        default: begin
          corrCos = neg(iSin);
          corrSin = iCos;
        end
      endcase
    end
  end

  // Tag storage needs no reset; the pointers define what is live.
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= iTag;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oValid  <= 1'b0;
      oCos    <= '0;
      oSin    <= '0;
      oErr    <= 1'b0;
      oOrphan <= 1'b0;
    end else begin
      if (pop) begin
        oValid <= 1'b1;
        oCos   <= corrCos;
        oSin   <= corrSin;
        oErr   <= !oneHot;
      end else if (iReady) begin
        oValid <= 1'b0;
      end
      if (accept && empty) oOrphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_fixedpoint_quadrant_restore.sv
// Randomized self-checking bench with a queue-based reference model
// for the CORDIC quadrant-restore back-end.
module tb_cordic_fixedpoint_quadrant_restore;

  localparam int W = 24;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iTag_valid;
  logic [7:0]    iTag;
  logic          oTag_ready;
  logic [CW-1:0] oTag_count;
  logic          iData_valid;
  logic [W-1:0]  iCos, iSin;
  logic          oData_ready;
  logic          oValid;
  logic [W-1:0]  oCos, oSin;
  logic          oErr, oOrphan;
  logic          iReady;

  cordic_fixedpoint_quadrant_restore #(.W(W), .DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iTag_valid(iTag_valid), .iTag(iTag),
    .oTag_ready(oTag_ready), .oTag_count(oTag_count),
    .iData_valid(iData_valid), .iCos(iCos), .iSin(iSin),
    .oData_ready(oData_ready),
    .oValid(oValid), .oCos(oCos), .oSin(oSin),
    .oErr(oErr), .oOrphan(oOrphan), .iReady(iReady)
  );

  always #5 iClk = ~iClk;

  int nChk = 0;
  int nPass = 0;

  logic [7:0]   q[$];
  bit           mValid, mErr, mOrph;
  logic [W-1:0] mCos, mSin;

  function automatic logic [W-1:0] rneg(input logic [W-1:0] x);
    longint v, r;
    longint maxv;
    maxv = (longint'(1) << (W - 1)) - 1;
    v = longint'($signed(x));
    r = -v;
    if (r > maxv) r = maxv;
    return r[W-1:0];
  endfunction

  task automatic model_load(input logic [7:0] t,
                            input logic [W-1:0] c, s);
    int nb, k;
    nb = 0;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (t[i]) begin nb++; k = i; end
    mValid = 1;
    mErr = (nb != 1);
    mCos = '0;
    mSin = '0;
    if (nb == 1) begin
      case (k / 2)
        0: begin mCos = c;       mSin = s;       end
        1: begin mCos = s;       mSin = rneg(c); end
        2: begin mCos = rneg(c); mSin = rneg(s); end
        default: begin mCos = rneg(s); mSin = c; end
      endcase
    end
  endtask

  task automatic step(input bit rst, input bit tv,
                      input logic [7:0] tg, input bit dv,
                      input logic [W-1:0] c, input logic [W-1:0] s,
                      input bit rd);
    bit tr, dr;
    iRst_n = !rst;
    iTag_valid = tv;
    iTag = tg;
    iData_valid = dv;
    iCos = c;
    iSin = s;
    iReady = rd;
    if (rst) begin
      q.delete();
      mValid = 0; mErr = 0; mOrph = 0; mCos = '0; mSin = '0;
    end else begin
      tr = (q.size() != DEPTH);
      dr = !mValid || rd;
      if (dv && dr) begin
        if (q.size() != 0) model_load(q.pop_front(), c, s);
        else begin
          mOrph = 1;
          if (rd) mValid = 0;
        end
      end else if (rd) mValid = 0;
      if (tv && tr) q.push_back(tg);
    end
    @(negedge iClk);
  endtask

  task automatic idle(input bit rd);
    step(0, 0, 8'h00, 0, '0, '0, rd);
  endtask

  task automatic test_reset;
    step(1, 0, 8'h00, 0, '0, '0, 1);
    step(1, 0, 8'h00, 0, '0, '0, 1);
    nChk++;
    if ({oValid, oErr, oOrphan, oCos, oSin} !== '0)
      $display("FAIL reset_out got v%0b e%0b o%0b %h %h exp 0",
               oValid, oErr, oOrphan, oCos, oSin);
    else nPass++;
    nChk++;
    if ({oTag_ready, oData_ready, oTag_count} !== {2'b11, CW'(0)})
      $display("FAIL reset_rdy got tr%0b dr%0b cnt%0d exp 1 1 0",
               oTag_ready, oData_ready, oTag_count);
    else nPass++;
  endtask

  task automatic test_basic;
    step(0, 1, 8'h04, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h200000, 24'h100000, 1);
    nChk++;
    if ({oValid, oErr, oCos, oSin} !== {2'b10, 24'h100000, 24'hE00000})
      $display("FAIL basic got v%0b e%0b %h %h exp 1 0 100000 e00000",
               oValid, oErr, oCos, oSin);
    else nPass++;
    idle(1);
    nChk++;
    if (oValid !== 1'b0)
      $display("FAIL basic_clear got %0b exp 0", oValid);
    else nPass++;
  endtask

  task automatic test_sequence;
    logic [7:0]     tags [4];
    logic [2*W-1:0] exp  [4];
    tags = '{8'h01, 8'h10, 8'h40, 8'h80};
    exp  = '{{24'h300000, 24'h080000}, {24'hD00000, 24'hF80000},
             {24'hF80000, 24'h300000}, {24'hF80000, 24'h300000}};
    for (int i = 0; i < 4; i++) step(0, 1, tags[i], 0, '0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 8'h00, 1, 24'h300000, 24'h080000, 1);
      nChk++;
      if ({oValid, oErr, oCos, oSin} !== {2'b10, exp[i]})
        $display("FAIL seq%0d got v%0b e%0b %h %h exp %h",
                 i, oValid, oErr, oCos, oSin, exp[i]);
      else nPass++;
    end
    idle(1);
  endtask

  task automatic test_saturation;
    step(0, 1, 8'h20, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h800000, 24'h800000, 1);
    nChk++;
    if ({oValid, oErr, oCos, oSin} !== {2'b10, 24'h7FFFFF, 24'h7FFFFF})
      $display("FAIL sat got v%0b e%0b %h %h exp 1 0 7fffff 7fffff",
               oValid, oErr, oCos, oSin);
    else nPass++;
    idle(1);
  endtask

  task automatic test_full;
    for (int i = 0; i < DEPTH; i++)
      step(0, 1, 8'(1 << (i % 8)), 0, '0, '0, 1);
    nChk++;
    if ({oTag_ready, oTag_count} !== {1'b0, CW'(DEPTH)})
      $display("FAIL full got tr%0b cnt%0d exp 0 %0d",
               oTag_ready, oTag_count, DEPTH);
    else nPass++;
    step(0, 1, 8'h03, 0, '0, '0, 1);
    nChk++;
    if (oTag_count !== CW'(DEPTH))
      $display("FAIL full_ign got %0d exp %0d", oTag_count, DEPTH);
    else nPass++;
    step(0, 0, 8'h00, 1, 24'h123456, 24'h654321, 1);
    nChk++;
    if ({oTag_ready, oTag_count, oCos, oSin} !==
        {1'b1, CW'(DEPTH - 1), 24'h123456, 24'h654321})
      $display("FAIL full_pop got tr%0b cnt%0d %h %h exp 1 %0d",
               oTag_ready, oTag_count, oCos, oSin, DEPTH - 1);
    else nPass++;
    for (int i = 1; i < DEPTH; i++)
      step(0, 0, 8'h00, 1, 24'(i), 24'(3 * i), 1);
    nChk++;
    if ({oTag_count, oErr, oCos, oSin} !== {CW'(0), mErr, mCos, mSin})
      $display("FAIL full_drain got cnt%0d e%0b %h %h exp 0 %0b %h %h",
               oTag_count, oErr, oCos, oSin, mErr, mCos, mSin);
    else nPass++;
    idle(1);
  endtask

  task automatic test_backpressure;
    logic [2*W-1:0] held;
    step(0, 1, 8'h02, 0, '0, '0, 1);
    step(0, 1, 8'h08, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h111111, 24'h222222, 0);
    held = {oCos, oSin};
    nChk++;
    if ({oValid, oData_ready, held} !== {2'b10, 24'h111111, 24'h222222})
      $display("FAIL bp_first got v%0b dr%0b %h exp 1 0 111111222222",
               oValid, oData_ready, held);
    else nPass++;
    step(0, 0, 8'h00, 1, 24'h333333, 24'h444444, 0);
    nChk++;
    if ({oValid, oCos, oSin, oTag_count} !== {1'b1, held, CW'(1)})
      $display("FAIL bp_hold got v%0b %h %h cnt%0d exp held cnt1",
               oValid, oCos, oSin, oTag_count);
    else nPass++;
    step(0, 0, 8'h00, 1, 24'h333333, 24'h444444, 1);
    nChk++;
    if ({oValid, oCos, oSin} !== {1'b1, 24'h444444, 24'hCCCCCD})
      $display("FAIL bp_release got v%0b %h %h exp 1 444444 cccccd",
               oValid, oCos, oSin);
    else nPass++;
    idle(1);
  endtask

  task automatic test_err;
    step(0, 1, 8'h03, 0, '0, '0, 1);
    step(0, 1, 8'h00, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h0ABCDE, 24'h012345, 1);
    nChk++;
    if ({oValid, oErr, oCos, oSin} !== {2'b11, 48'h0})
      $display("FAIL err_multi got v%0b e%0b %h %h exp 1 1 0 0",
               oValid, oErr, oCos, oSin);
    else nPass++;
    step(0, 0, 8'h00, 1, 24'h0ABCDE, 24'h012345, 1);
    nChk++;
    if ({oValid, oErr, oCos, oSin, oTag_count} !== {2'b11, 48'h0, CW'(0)})
      $display("FAIL err_zero got v%0b e%0b %h %h cnt%0d exp 1 1 0 0 0",
               oValid, oErr, oCos, oSin, oTag_count);
    else nPass++;
    idle(1);
  endtask

  task automatic test_orphan;
    step(1, 0, 8'h00, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h100000, 24'h100000, 1);
    nChk++;
    if ({oValid, oOrphan, oCos} !== {2'b01, 24'h0})
      $display("FAIL orphan got v%0b o%0b %h exp 0 1 0",
               oValid, oOrphan, oCos);
    else nPass++;
    step(0, 1, 8'h01, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h000123, 24'h000456, 1);
    nChk++;
    if ({oValid, oOrphan, oCos, oSin} !== {2'b11, 24'h000123, 24'h000456})
      $display("FAIL orphan_sticky got v%0b o%0b %h %h exp 1 1 123 456",
               oValid, oOrphan, oCos, oSin);
    else nPass++;
    step(1, 0, 8'h00, 0, '0, '0, 1);
    nChk++;
    if (oOrphan !== 1'b0)
      $display("FAIL orphan_rst got %0b exp 0", oOrphan);
    else nPass++;
  endtask

  task automatic test_midreset;
    step(0, 1, 8'h01, 0, '0, '0, 1);
    step(0, 1, 8'h01, 0, '0, '0, 1);
    step(0, 0, 8'h00, 1, 24'h555555, 24'h000001, 0);
    step(1, 0, 8'h00, 0, '0, '0, 0);
    nChk++;
    if ({oValid, oTag_count, oCos, oData_ready} !== {1'b0, CW'(0), 24'h0, 1'b1})
      $display("FAIL midrst got v%0b cnt%0d %h dr%0b exp 0 0 0 1",
               oValid, oTag_count, oCos, oData_ready);
    else nPass++;
  endtask

  task automatic test_random;
    int errs;
    logic [7:0] tg;
    errs = 0;
    for (int n = 0; n < 3000; n++) begin
      tg = ($urandom_range(0, 9) == 0) ? 8'($urandom)
                                       : 8'(1 << $urandom_range(0, 7));
      step(0, $urandom_range(0, 2) != 0, tg, $urandom_range(0, 2) != 0,
           W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
      nChk++;
      if ({oValid, oErr, oOrphan, oTag_count, oTag_ready} !==
          {mValid, mErr, mOrph, CW'(q.size()), q.size() != DEPTH} ||
          (mValid && {oCos, oSin} !== {mCos, mSin})) begin
        if (errs < 10)
          $display("FAIL rand%0d got v%0b e%0b o%0b c%0d %h %h exp v%0b e%0b o%0b c%0d %h %h",
                   n, oValid, oErr, oOrphan, oTag_count, oCos, oSin,
                   mValid, mErr, mOrph, q.size(), mCos, mSin);
        errs++;
      end else nPass++;
    end
  endtask

  initial begin
    iRst_n = 0; iTag_valid = 0; iTag = 0; iData_valid = 0;
    iCos = 0; iSin = 0; iReady = 1;
    @(negedge iClk);
    test_reset;
    test_basic;
    test_sequence;
    test_saturation;
    test_full;
    test_backpressure;
    test_err;
    test_orphan;
    test_midreset;
    test_random;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
